ks_slice_seq: RTL and testbench

Multi-cycle 64-bit adder controller that shares one 8-bit `ks_adder` carry-lookahead slice between two requesters. It arbitrates round-robin between the requesters and latches the winning operands. It then steps the slice across the operand one byte per cycle, rippling the carry through a register, and returns sum/carry-out on a valid/ready response port. It is the area-reduced alternative to the fully parallel eight-slice 64-bit adder.

---
 rtl/ks_slice_seq_if.sv | 19 +
 rtl/ks_slice_seq.sv | 90 +++++++++
 tb/tb_ks_slice_seq.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_slice_seq_if.sv
// ks_slice_seq_if: two requester ports and one response port of the shared-slice 64-bit adder.
interface ks_slice_seq_if #(parameter int WIDTH = 64);
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             resp_valid, resp_ready, resp_cout, resp_id;
    logic [WIDTH-1:0] resp_sum;
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_sum, resp_cout, resp_id
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_sum, resp_cout, resp_id
    );
endinterface

// File: rtl/ks_slice_seq.sv
// ks_slice_seq: round-robin shared 8-bit Kogge-Stone slice stepped byte by byte over WIDTH-bit operands.
module ks_adder (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [7:0] w_g, w_p;
    always_comb begin
        w_g = (i_a & i_b) | {7'b0, (i_a[0] ^ i_b[0]) & i_cin};
        w_p = i_a ^ i_b;
        // descending k reads the previous level's value at k-d before it is overwritten
        for (int d = 1; d < 8; d = d * 2)
            for (int k = 7; k >= d; k--) begin
                w_g[k] = w_g[k] | (w_p[k] & w_g[k-d]);
                w_p[k] = w_p[k] & w_p[k-d];
            end
        o_sum  = (i_a ^ i_b) ^ {w_g[6:0], i_cin};
        o_cout = w_g[7];
    end
endmodule

module ks_slice_seq #(parameter int WIDTH = 64) (
    input logic clk,
    input logic rst,
    ks_slice_seq_if.slave bus
);
    localparam int N  = WIDTH / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry, r_cout, r_id, r_last;
    logic             w_gnt0, w_gnt1, w_acc, w_last_step, w_c;
    logic [7:0]       w_s;

    ks_adder u_slice (
        .i_a    (r_a[{r_idx, 3'b000} +: 8]),
        .i_b    (r_b[{r_idx, 3'b000} +: 8]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_gnt0         = bus.req0_valid & (~bus.req1_valid | r_last);
        w_gnt1         = bus.req1_valid & (~bus.req0_valid | ~r_last);
        bus.req0_ready = (r_state == IDLE) & w_gnt0 & ~rst;
        bus.req1_ready = (r_state == IDLE) & w_gnt1 & ~rst;
        w_acc          = bus.req0_ready | bus.req1_ready;
        w_last_step    = r_idx == IW'(N - 1);
        w_next = (r_state == IDLE && w_acc)          ? RUN  :
                 (r_state == RUN  && w_last_step)    ? DONE :
                 (r_state == DONE && bus.resp_ready) ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_acc) begin
            r_a     <= bus.req1_ready ? bus.req1_a : bus.req0_a;
            r_b     <= bus.req1_ready ? bus.req1_b : bus.req0_b;
            r_carry <= bus.req1_ready ? bus.req1_cin : bus.req0_cin;
            r_id    <= bus.req1_ready;
            r_last  <= bus.req1_ready;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[{r_idx, 3'b000} +: 8] <= w_s;
            r_carry <= w_c;
            r_idx   <= r_idx + IW'(1);
            if (w_last_step)
                r_cout <= w_c;
        end
    end

    assign bus.resp_valid = r_state == DONE;
    assign bus.resp_sum   = r_sum;
    assign bus.resp_cout  = r_cout;
    assign bus.resp_id    = r_id;
endmodule

// File: tb/tb_ks_slice_seq.sv
// tb_ks_slice_seq: directed scenarios plus a randomized two-requester regression against a 65-bit golden sum.
module tb_ks_slice_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    typedef struct {logic id; logic [64:0] exp;} exp_t;

    always #5 clk = ~clk;

    ks_slice_seq_if #(.WIDTH(64)) bus ();
    ks_slice_seq #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [64:0] golden(logic [63:0] a, logic [63:0] b, logic c);
        return {1'b0, a} + {1'b0, b} + {64'b0, c};
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
        bus.resp_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++)
            if (bus.resp_valid) ok = 1;
            else @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        #1;
        checks++;
        if ({bus.resp_valid, bus.resp_cout, bus.resp_id, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.resp_valid, bus.resp_cout, bus.resp_id, bus.req0_ready, bus.req1_ready});
        end
        checks++;
        if (bus.resp_sum !== 64'h0) begin
            errors++; $display("FAIL reset_sum got %h exp 0", bus.resp_sum);
        end
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant got %b exp 01", {bus.req1_ready, bus.req0_ready});
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
    endtask

    task automatic test_max_carry();
        bit ok;
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = '1; bus.req0_b = 64'd1; bus.req0_cin = 0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++; $display("FAIL max_ready got %b exp 1", bus.req0_ready);
        end
        @(negedge clk);
        bus.req0_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) begin
                checks++;
                if (bus.resp_valid !== 1'b0) begin
                    errors++; $display("FAIL max_early_valid got %b exp 0", bus.resp_valid);
                end
            end
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++; $display("FAIL max_latency got %b exp 1", bus.resp_valid);
        end
        checks++;
        if ({bus.resp_id, bus.resp_cout, bus.resp_sum} !== {2'b01, 64'h0}) begin
            errors++;
            $display("FAIL max_result got id=%b cout=%b sum=%h exp id=0 cout=1 sum=0",
                     bus.resp_id, bus.resp_cout, bus.resp_sum);
        end
        bus.resp_ready = 1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL max_release got %b exp 0", bus.resp_valid);
        end
        bus.resp_ready = 0;
        ok = 1;
    endtask

    task automatic test_cin_only();
        bit ok;
        bus.req1_valid = 1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1;
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++; $display("FAIL cin_ready got %b exp 10", {bus.req1_ready, bus.req0_ready});
        end
        @(negedge clk);
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            errors++; $display("FAIL cin_ready_pulse got %b exp 0", bus.req1_ready);
        end
        bus.req1_valid = 0;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL cin_timeout got no resp_valid exp resp_valid");
        end
        checks++;
        if ({bus.resp_id, bus.resp_cout, bus.resp_sum} !== {2'b10, 64'h1}) begin
            errors++;
            $display("FAIL cin_result got id=%b cout=%b sum=%h exp id=1 cout=0 sum=1",
                     bus.resp_id, bus.resp_cout, bus.resp_sum);
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
    endtask

    task automatic test_contention();
        bit ok;
        logic [64:0] exp1, exp;
        do_reset();
        bus.req0_a = 64'h0123_4567_89AB_CDEF; bus.req0_b = 64'h1111_1111_1111_1111; bus.req0_cin = 0;
        bus.req1_a = {$urandom, $urandom}; bus.req1_b = {$urandom, $urandom}; bus.req1_cin = 1'($urandom);
        exp1 = golden(bus.req1_a, bus.req1_b, bus.req1_cin);
        bus.req0_valid = 1; bus.req1_valid = 1; bus.resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL cont_timeout op %0d got no resp_valid exp resp_valid", k);
            end
            checks++;
            if (bus.resp_id !== 1'(k)) begin
                errors++; $display("FAIL cont_grant op %0d got %b exp %0d", k, bus.resp_id, k % 2);
            end
            exp = bus.resp_id ? exp1 : 65'h0_1234_5678_9ABC_DF00;
            checks++;
            if ({bus.resp_cout, bus.resp_sum} !== exp) begin
                errors++; $display("FAIL cont_result op %0d got %h exp %h", k, {bus.resp_cout, bus.resp_sum}, exp);
            end
            @(negedge clk);
        end
        bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 0;
    endtask

    task automatic test_backpressure();
        bit ok, bad;
        logic [64:0] exp0, exp1;
        @(negedge clk);
        bus.req0_a = {$urandom, $urandom}; bus.req0_b = {$urandom, $urandom}; bus.req0_cin = 1;
        exp0 = golden(bus.req0_a, bus.req0_b, 1'b1);
        bus.req0_valid = 1;
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_a = {$urandom, $urandom}; bus.req1_b = ~bus.req1_a; bus.req1_cin = 1;
        exp1 = golden(bus.req1_a, bus.req1_b, 1'b1);
        bus.req1_valid = 1;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_timeout got no resp_valid exp resp_valid");
        end
        checks++;
        if ({bus.resp_id, bus.resp_cout, bus.resp_sum} !== {1'b0, exp0}) begin
            errors++; $display("FAIL bp_result got %h exp %h", {bus.resp_id, bus.resp_cout, bus.resp_sum}, {1'b0, exp0});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad = {bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_sum, bus.req0_ready, bus.req1_ready}
                  !== {1'b1, 1'b0, exp0, 2'b00};
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b id=%b cout=%b sum=%h rdy=%b%b exp v=1 id=0 %h rdy=00",
                         i, bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_sum,
                         bus.req1_ready, bus.req0_ready, exp0);
            end
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
        checks++;
        if ({bus.resp_valid, bus.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release got valid=%b rdy1=%b exp valid=0 rdy1=1", bus.resp_valid, bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 0;
        wait_valid(ok);
        checks++;
        if (!ok || {bus.resp_id, bus.resp_cout, bus.resp_sum} !== {1'b1, exp1}) begin
            errors++; $display("FAIL bp_next got %h exp %h", {bus.resp_id, bus.resp_cout, bus.resp_sum}, {1'b1, exp1});
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
    endtask

    task automatic test_reset_mid_run();
        bit ok, seen;
        logic [64:0] exp1;
        bus.req0_a = '1; bus.req0_b = {$urandom, $urandom}; bus.req0_cin = 1; bus.req0_valid = 1;
        @(negedge clk);
        bus.req0_valid = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_cout, bus.resp_id, bus.req0_ready, bus.req1_ready, bus.resp_sum} !== 69'h0) begin
            errors++;
            $display("FAIL rst_run_outputs got v=%b c=%b id=%b rdy=%b%b sum=%h exp all 0", bus.resp_valid,
                     bus.resp_cout, bus.resp_id, bus.req1_ready, bus.req0_ready, bus.resp_sum);
        end
        rst = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.resp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_run_aborted got resp_valid=1 exp 0");
        end
        bus.req1_a = {$urandom, $urandom}; bus.req1_b = {$urandom, $urandom}; bus.req1_cin = 0;
        exp1 = golden(bus.req1_a, bus.req1_b, 1'b0);
        bus.req1_valid = 1;
        @(negedge clk);
        bus.req1_valid = 0;
        wait_valid(ok);
        checks++;
        if (!ok || {bus.resp_id, bus.resp_cout, bus.resp_sum} !== {1'b1, exp1}) begin
            errors++; $display("FAIL rst_run_new got %h exp %h", {bus.resp_id, bus.resp_cout, bus.resp_sum}, {1'b1, exp1});
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
    endtask

    task automatic test_random(input int nops);
        logic [63:0] ra[2], rb[2];
        logic        rc[2];
        bit          rv[2], racc[2];
        exp_t        q[$];
        exp_t        e;
        int          issued = 0;
        int          cyc = 0;
        for (int x = 0; x < 2; x++) begin rv[x] = 0; racc[x] = 0; end
        while ((issued < nops || q.size() != 0 || rv[0] || rv[1]) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            for (int x = 0; x < 2; x++) begin
                if (racc[x]) begin rv[x] = 0; racc[x] = 0; end
                if (!rv[x] && issued < nops && $urandom_range(0, 3) != 0) begin
                    ra[x] = {$urandom, $urandom};
                    rb[x] = ($urandom_range(0, 3) == 0) ? ~ra[x] : {$urandom, $urandom};
                    rc[x] = 1'($urandom);
                    rv[x] = 1;
                    issued++;
                end
            end
            bus.req0_valid = rv[0]; bus.req0_a = ra[0]; bus.req0_b = rb[0]; bus.req0_cin = rc[0];
            bus.req1_valid = rv[1]; bus.req1_a = ra[1]; bus.req1_b = rb[1]; bus.req1_cin = rc[1];
            bus.resp_ready = 1'($urandom);
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                checks++;
                if (bus.req0_ready && bus.req1_ready) begin
                    errors++; $display("FAIL rand_both_ready got 11 exp one-hot at cycle %0d", cyc);
                end
            end
            for (int x = 0; x < 2; x++)
                if ((x == 0) ? bus.req0_ready : bus.req1_ready) begin
                    q.push_back('{1'(x), golden(ra[x], rb[x], rc[x])});
                    racc[x] = 1;
                end
            if (bus.resp_valid && bus.resp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got response id=%b exp none", bus.resp_id);
                end else begin
                    e = q.pop_front();
                    if ({bus.resp_id, bus.resp_cout, bus.resp_sum} !== {e.id, e.exp}) begin
                        errors++;
                        $display("FAIL rand_result got id=%b %h exp id=%b %h", bus.resp_id,
                                 {bus.resp_cout, bus.resp_sum}, e.id, e.exp);
                    end
                end
            end
        end
        checks++;
        if (cyc >= 60000 || q.size() != 0) begin
            errors++; $display("FAIL rand_drain got %0d outstanding after %0d cycles exp 0", q.size(), cyc);
        end
        idle_inputs();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_max_carry();
        test_cin_only();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
